// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter in front of a single-port synchronous memory.
// One access is issued per cycle. Read data is routed back to the requester
// that issued the read through a tag pipeline that matches the memory read latency.
module mem_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 8,
   parameter int RD_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_add,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         mem_add,
   output logic [DATA_W-1:0]         mem_data_in,
   output logic                      mem_we,
   input  logic [DATA_W-1:0]         mem_data_out
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   r_ptr;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_rvalid;
   logic [ADDR_W-1:0]  r_mem_add;
   logic [DATA_W-1:0]  r_mem_data_in;
   logic               r_mem_we;
   logic               r_tag_vld [RD_LAT];
   logic [PTR_W-1:0]   r_tag_idx [RD_LAT];

   logic [NUM_REQ-1:0] w_elig;
   logic               w_found;
   logic [PTR_W-1:0]   w_win;
   logic [PTR_W-1:0]   w_ptr_nxt;
   logic [NUM_REQ-1:0] w_gnt_nxt;
   logic [NUM_REQ-1:0] w_rvalid_nxt;
   int unsigned        w_idx;

   // A requester that holds the grant this cycle is masked so it cannot win twice in a row.
   assign w_elig = req & ~r_gnt;

   // Search from the pointer upward and wrap around to find the first eligible requester.
   always_comb begin
      w_found   = 1'b0;
      w_win     = '0;
      w_idx     = 0;
      w_gnt_nxt = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = 32'(r_ptr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[PTR_W-1:0];
         end
      end
      w_gnt_nxt[w_win] = w_found;
      w_ptr_nxt = (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
   end

   // Decode the tag pipeline output into a one-hot read-valid strobe.
   always_comb begin
      w_rvalid_nxt = '0;
      w_rvalid_nxt[r_tag_idx[RD_LAT-1]] = r_tag_vld[RD_LAT-1];
   end

   // Register the grant, the memory port and the pointer. On an idle cycle the address and data hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr         <= '0;
         r_gnt         <= '0;
         r_mem_we      <= 1'b0;
         r_mem_add     <= '0;
         r_mem_data_in <= '0;
      end else begin
         r_gnt    <= w_gnt_nxt;
         r_mem_we <= 1'b0;
         if (w_found) begin
            r_mem_we      <= req_we[w_win];
            r_mem_add     <= req_add[w_win*ADDR_W +: ADDR_W];
            r_mem_data_in <= req_data[w_win*DATA_W +: DATA_W];
            r_ptr         <= w_ptr_nxt;
         end
      end
   end

   // The tag pipeline carries the read owner alongside the memory access. Reset drops in-flight reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < RD_LAT; s++) begin
            r_tag_vld[s] <= 1'b0;
            r_tag_idx[s] <= '0;
         end
         r_rvalid <= '0;
      end else begin
         r_tag_vld[0] <= w_found & ~req_we[w_win];
         r_tag_idx[0] <= w_win;
         for (int unsigned s = 1; s < RD_LAT; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_idx[s] <= r_tag_idx[s-1];
         end
         r_rvalid <= w_rvalid_nxt;
      end
   end

   assign gnt         = r_gnt;
   assign rvalid      = r_rvalid;
   assign rdata       = mem_data_out;
   assign mem_add     = r_mem_add;
   assign mem_data_in = r_mem_data_in;
   assign mem_we      = r_mem_we;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter. Two instances share the same requests: one with RD_LAT=1 and one with RD_LAT=2.
// Each instance has its own memory model. Read results are scoreboarded per instance.
module tb_mem_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  req_we = '0;
   logic [23:0] req_add = '0;
   logic [31:0] req_data = '0;

   logic [3:0] gnt1, rvalid1, gnt2, rvalid2;
   logic [7:0] rdata1, rdata2, din1, din2, dout1, dout2;
   logic [5:0] add1, add2;
   logic       we1, we2;

   int n_checks = 0;
   int n_errors = 0;
   logic mem_clr = 1'b1;
   logic mon_en  = 1'b0;

   always #5 clk = ~clk;

   mem_rr_arbiter #(.NUM_REQ(4), .ADDR_W(6), .DATA_W(8), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_add(req_add),
      .req_data(req_data), .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1),
      .mem_add(add1), .mem_data_in(din1), .mem_we(we1), .mem_data_out(dout1));

   mem_rr_arbiter #(.NUM_REQ(4), .ADDR_W(6), .DATA_W(8), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_add(req_add),
      .req_data(req_data), .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
      .mem_add(add2), .mem_data_in(din2), .mem_we(we2), .mem_data_out(dout2));

   // Memory models. A location that has never been written reads as (address ^ 8'h3C).
   logic [7:0] m1 [64];
   logic [7:0] m2 [64];
   logic       wr1 [64];
   logic       wr2 [64];
   logic [7:0] rd1, rd2a, rd2b;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) begin
            wr1[i] <= 1'b0;
            wr2[i] <= 1'b0;
         end
      end else begin
         if (we1) begin
            m1[add1]  <= din1;
            wr1[add1] <= 1'b1;
         end
         if (we2) begin
            m2[add2]  <= din2;
            wr2[add2] <= 1'b1;
         end
         rd1  <= wr1[add1] ? m1[add1] : ({2'b00, add1} ^ 8'h3C);
         rd2a <= wr2[add2] ? m2[add2] : ({2'b00, add2} ^ 8'h3C);
         rd2b <= rd2a;
      end
   end
   assign dout1 = rd1;
   assign dout2 = rd2b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] rv;
      logic [7:0] d;
   } rd_t;
   rd_t q1[$];
   rd_t q2[$];

   // Scoreboard monitors: every rvalid strobe must match the oldest outstanding read.
   always @(negedge clk) begin
      rd_t e;
      if (rst_n && mon_en && rvalid1 !== 4'b0000) begin
         if (q1.size() == 0) chk("rvalid1_unexpected", 32'(rvalid1), 32'd0);
         else begin
            e = q1.pop_front();
            chk("rvalid1", 32'(rvalid1), 32'(e.rv));
            chk("rdata1", 32'(rdata1), 32'(e.d));
         end
      end
   end

   always @(negedge clk) begin
      rd_t e;
      if (rst_n && mon_en && rvalid2 !== 4'b0000) begin
         if (q2.size() == 0) chk("rvalid2_unexpected", 32'(rvalid2), 32'd0);
         else begin
            e = q2.pop_front();
            chk("rvalid2", 32'(rvalid2), 32'(e.rv));
            chk("rdata2", 32'(rdata2), 32'(e.d));
         end
      end
   end

   typedef struct {
      logic [3:0] req;
      logic [3:0] we;
      logic [5:0] abase;
      logic [7:0] dbase;
      logic [3:0] gnt;
      logic       mwe;
      logic [5:0] madd;
      logic [7:0] mdin;
      logic [7:0] rdata;
   } vec_t;
   vec_t vt[$];

   function automatic vec_t mk(logic [3:0] r, logic [3:0] w, logic [5:0] ab, logic [7:0] db,
                               logic [3:0] g, logic mw, logic [5:0] ma, logic [7:0] md,
                               logic [7:0] rd);
      vec_t v;
      v.req = r;  v.we = w;  v.abase = ab; v.dbase = db;
      v.gnt = g;  v.mwe = mw; v.madd = ma; v.mdin = md; v.rdata = rd;
      return v;
   endfunction

   // Requester i presents address abase+i and data dbase+i.
   task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [5:0] ab,
                        input logic [7:0] db);
      req    = r;
      req_we = w;
      for (int i = 0; i < 4; i++) begin
         req_add[i*6 +: 6]  = ab + 6'(i);
         req_data[i*8 +: 8] = db + 8'(i);
      end
   endtask

   initial begin
      vec_t v;
      rd_t  e;

      // Reference vectors. Expected values are derived by hand from the pointer progression.
      vt.push_back(mk(4'b0001, 4'b0000, 6'h10, 8'h00, 4'b0001, 1'b0, 6'h10, 8'h00, 8'h2C));
      vt.push_back(mk(4'b0000, 4'b0000, 6'h10, 8'h00, 4'b0000, 1'b0, 6'h10, 8'h00, 8'h00));
      vt.push_back(mk(4'b0010, 4'b0010, 6'h04, 8'hA4, 4'b0010, 1'b1, 6'h05, 8'hA5, 8'h00));
      vt.push_back(mk(4'b0000, 4'b0000, 6'h04, 8'hA4, 4'b0000, 1'b0, 6'h05, 8'hA5, 8'h00));
      vt.push_back(mk(4'b0100, 4'b0000, 6'h03, 8'h00, 4'b0100, 1'b0, 6'h05, 8'h02, 8'hA5));
      vt.push_back(mk(4'b0000, 4'b0000, 6'h03, 8'h00, 4'b0000, 1'b0, 6'h05, 8'h02, 8'h00));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b1000, 1'b0, 6'h23, 8'h43, 8'h1F));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b0001, 1'b0, 6'h20, 8'h40, 8'h1C));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b0010, 1'b0, 6'h21, 8'h41, 8'h1D));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b0100, 1'b0, 6'h22, 8'h42, 8'h1E));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b1000, 1'b0, 6'h23, 8'h43, 8'h1F));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b0001, 1'b0, 6'h20, 8'h40, 8'h1C));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b0010, 1'b0, 6'h21, 8'h41, 8'h1D));
      vt.push_back(mk(4'b1111, 4'b0000, 6'h20, 8'h40, 4'b0100, 1'b0, 6'h22, 8'h42, 8'h1E));
      vt.push_back(mk(4'b1001, 4'b1111, 6'h20, 8'h40, 4'b1000, 1'b1, 6'h23, 8'h43, 8'h00));
      vt.push_back(mk(4'b1001, 4'b1111, 6'h20, 8'h40, 4'b0001, 1'b1, 6'h20, 8'h40, 8'h00));
      vt.push_back(mk(4'b1001, 4'b1111, 6'h20, 8'h40, 4'b1000, 1'b1, 6'h23, 8'h43, 8'h00));
      vt.push_back(mk(4'b0010, 4'b0000, 6'h30, 8'h50, 4'b0010, 1'b0, 6'h31, 8'h51, 8'h0D));
      vt.push_back(mk(4'b0010, 4'b0000, 6'h30, 8'h50, 4'b0000, 1'b0, 6'h31, 8'h51, 8'h00));
      vt.push_back(mk(4'b0010, 4'b0000, 6'h30, 8'h50, 4'b0010, 1'b0, 6'h31, 8'h51, 8'h0D));
      vt.push_back(mk(4'b0000, 4'b0000, 6'h30, 8'h50, 4'b0000, 1'b0, 6'h31, 8'h51, 8'h00));
      vt.push_back(mk(4'b1000, 4'b0000, 6'h20, 8'h40, 4'b1000, 1'b0, 6'h23, 8'h43, 8'h43));
      vt.push_back(mk(4'b0000, 4'b0000, 6'h20, 8'h40, 4'b0000, 1'b0, 6'h23, 8'h43, 8'h00));

      // Hold reset with random requests. All outputs must stay at zero.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
         @(posedge clk); #1;
         chk("rst_gnt", 32'(gnt1), 32'd0);
         chk("rst_rvalid", 32'(rvalid1), 32'd0);
         chk("rst_mem_we", 32'(we1), 32'd0);
         chk("rst_mem_add", 32'(add1), 32'd0);
         chk("rst_mem_data_in", 32'(din1), 32'd0);
      end
      @(negedge clk);
      drive(4'b0000, 4'b0000, 6'h00, 8'h00);
      rst_n   = 1'b1;
      mem_clr = 1'b0;
      mon_en  = 1'b1;

      // Apply the vectors in order. Each read that is expected to be granted is pushed to the scoreboard.
      foreach (vt[k]) begin
         v = vt[k];
         @(negedge clk);
         drive(v.req, v.we, v.abase, v.dbase);
         if (v.gnt != 4'b0000 && !v.mwe) begin
            e.rv = v.gnt;
            e.d  = v.rdata;
            q1.push_back(e);
            q2.push_back(e);
         end
         @(posedge clk); #1;
         chk("gnt", 32'(gnt1), 32'(v.gnt));
         chk("gnt_lat2", 32'(gnt2), 32'(v.gnt));
         chk("mem_we", 32'(we1), 32'(v.mwe));
         chk("mem_add", 32'(add1), 32'(v.madd));
         chk("mem_data_in", 32'(din1), 32'(v.mdin));
      end

      // Async reset during an outstanding read. With RD_LAT=2 the read is dropped.
      // With RD_LAT=1 the data is already returned before reset.
      @(negedge clk);
      drive(4'b0100, 4'b0000, 6'h00, 8'h00);
      e.rv = 4'b0100;
      e.d  = 8'h3E;
      q1.push_back(e);
      @(posedge clk); #1;
      chk("midrst_gnt", 32'(gnt2), 32'h4);
      @(negedge clk);
      drive(4'b0000, 4'b0000, 6'h00, 8'h00);
      @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_async_gnt", 32'(gnt2), 32'd0);
      chk("midrst_async_rvalid", 32'(rvalid2), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("midrst_rvalid2", 32'(rvalid2), 32'd0);
         chk("midrst_mem_add", 32'(add2), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1111, 4'b1111, 6'h08, 8'h60);
      @(posedge clk); #1;
      chk("postrst_gnt1", 32'(gnt1), 32'h1);
      chk("postrst_gnt2", 32'(gnt2), 32'h1);
      chk("postrst_rvalid2", 32'(rvalid2), 32'd0);
      @(posedge clk); #1;
      chk("postrst_gnt_next", 32'(gnt2), 32'h2);
      @(negedge clk);
      drive(4'b0000, 4'b0000, 6'h00, 8'h00);

      // Bounded drain: every outstanding read must have completed by now.
      repeat (6) @(posedge clk);
      #1;
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter that shares the single-port synchronous memory (`add`, `data_in`, `we`, `data_out`) between up to NUM_REQ requesters. It sits directly in front of the memory instance: it accepts read and write requests, issues one memory access per cycle, and routes read data back to the requester that issued the read, using a tag pipeline matched to the memory read latency.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 6, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, cycles from the address being driven to `mem_data_out` being valid (1..4)

- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  per-requester write enable; 1 = write, 0 = read
- req_add  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot, single-cycle grant; asserted in the cycle the access is on the memory port
- rvalid  out  NUM_REQ  one-hot, single-cycle read-data-valid strobe
- rdata  out  DATA_W  read data, equal to `mem_data_out`; qualified by `rvalid`
- mem_add  out  ADDR_W  memory address (registered)
- mem_data_in  out  DATA_W  memory write data (registered)
- mem_we  out  1  memory write enable (registered)
- mem_data_out  in  DATA_W  memory read data

## Operation

- Eligible set at each edge: `req & ~gnt`.
  - A requester that holds `gnt` in the current cycle is masked from that edge's arbitration.
  - This prevents a double grant when the requester keeps `req` high while it observes `gnt`.
- Priority pointer `ptr` (0..NUM_REQ-1; reset value 0) marks the highest-priority index. Search order: ptr, ptr+1, …, wrapping modulo NUM_REQ.
- When the eligible set is non-empty, winner w is chosen. At that edge:
  - `gnt` <= one-hot(w).
  - `mem_add` <= address of w, `mem_data_in` <= write data of w, `mem_we` <= `req_we[w]`.
  - `ptr` <= (w+1) mod NUM_REQ.
- When the eligible set is empty:
  - `gnt` <= 0 and `mem_we` <= 0.
  - `mem_add`, `mem_data_in` and `ptr` hold their values.
- A requester's `req_we`, `req_add` and `req_data` are sampled only at the edge where it wins. They may change after that edge.
- A requester deasserts `req` (or presents its next request) in the cycle it observes `gnt`.
- Reads use a tag pipeline of depth RD_LAT, holding a valid bit and a requester index.
  - A granted read enters the pipeline with valid=1; a write or an idle cycle enters with valid=0.
  - At the pipeline output, `rvalid[index]` = valid and `rdata` = `mem_data_out`.
- Writes produce no `rvalid`.
- Fairness: under continuous requests, a requester waits at most NUM_REQ-1 grants to other requesters before its own grant.
- Reset (rst_n low, asynchronous, any time, including mid-operation):
  - `gnt`=0, `rvalid`=0, `mem_we`=0, `mem_add`=0, `mem_data_in`=0, `ptr`=0.
  - The tag pipeline is cleared, so in-flight reads are dropped and never signalled.
  - Operation resumes at the first rising edge after rst_n returns high.

## Timing

- Request sampled at edge E0 → `gnt` and memory port driven in cycle E0..E1 → memory samples at E1.
- Grant latency: 1 cycle from the edge at which `req` is sampled.
- Read data: `rvalid` and `rdata` are valid RD_LAT cycles after the `gnt` cycle. For RD_LAT=1, that is the cycle immediately following `gnt`.
- Throughput: one memory access per cycle when two or more requesters are active. A single continuously requesting requester receives a grant every 2nd cycle because of the `gnt` mask.
- `rvalid` is registered with no combinational input path. `rdata` is a combinational pass-through of `mem_data_out`.
- Read-after-write to the same address from any requesters: the write is granted first, and the read granted in a later cycle returns the new data.

## Test plan

- Reset: hold rst_n low with random `req` → `gnt`=0, `rvalid`=0, `mem_we`=0, `mem_add`=0, `mem_data_in`=0. Release, then `req`=4'b0001 → `gnt`=0001 one cycle later (ptr=0).
- Write: req[1]=1, req_we[1]=1, add=5, data=8'hA5 → next cycle `gnt`=0010, `mem_we`=1, `mem_add`=5, `mem_data_in`=A5. The cycle after, `mem_we`=0 with `mem_add` held at 5.
- Read-back: after the write, req[2] reads add 5 → `gnt`=0100, `mem_we`=0. One cycle later (RD_LAT=1) `rvalid`=0100 and `rdata`=A5. No other `rvalid` bit is ever set.
- Round-robin: all four `req` held high for 8 cycles → grant sequence 0,1,2,3,0,1,2,3, one grant per cycle, with no cycle where `gnt` is zero.
- Pointer wrap: last grant went to 2, then `req`=4'b1001 held → grants 3, then 0, then 3. A single requester held alone → `gnt` alternates 1,0,1,0.
- Async reset mid-read: rst_n pulsed low in the cycle after a read's `gnt` (RD_LAT=2) → no `rvalid` ever appears for that read, ptr returns to 0, and the next grant follows reset priority.
